spi_master_fifo: RTL

Parametrised SPI master, successor to the single-buffer SPI transceiver.
- TX and RX FIFOs with valid/ready handshakes on both sides.
- Multiple chip selects, selectable bit order and an internal SCLK divider.
- Back-to-back words are sent as one frame with CS held low.
- Sits between a register/bus front end and off-chip SPI slaves.

---
 rtl/spi_master_fifo_pkg.sv | 23 ++
 rtl/spi_master_fifo_if.sv | 21 ++
 rtl/spi_sync_fifo.sv | 40 ++++
 rtl/spi_master_fifo.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/spi_master_fifo_pkg.sv
// Shared types and constants for the FIFO-buffered SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } spi_state_e;

    // {CPOL,CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Half-period counter width: holds 0 .. 2*width-1 without wrapping
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/spi_master_fifo_if.sv
// Bus-side word handshakes of the SPI master: TX push and RX pop.
interface spi_master_fifo_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push ignored when full, pop when empty.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty;

    assign count = wr_ptr - rd_ptr;
    assign full  = count[AW];
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; both sides may move in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write (contents need no reset)
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/spi_master_fifo.sv
// FIFO-buffered SPI master: back-to-back words share one CS-low frame.
// Optional build macro SPI_LOOPBACK_EN adds a 'loopback' input that feeds
// MOSI into the receive sampler instead of the spi_miso pin.
module spi_master_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8,
    localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_fifo_if.slave  bus,
    input  logic [1:0]        mode,
    input  logic              lsb_first,
    input  logic [CSW-1:0]    cs_sel,
    input  logic [DIV_W-1:0]  clk_div,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              busy,
    output logic              frame_done,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    spi_state_e       state, state_nx;
    logic [DIV_W-1:0] div_cnt, div_l;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg, rxreg, rx_shift, rx_word, tx_head;
    logic             cpol_l, cpha_l, lsb_l;
    logic [AW:0]      tx_count, rx_count;
    logic             tx_empty, rx_full, rx_pop, rx_space, rx_space_nx;
    logic             tick, last, sample_now, load_now, miso_s;
    logic             start, cont, tx_pop, rx_push;

    function automatic logic out_bit(input logic [WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    spi_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(bus.tx_valid), .din(bus.tx_data),
        .pop(tx_pop), .dout(tx_head), .count(tx_count)
    );

    spi_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(rx_push), .din(rx_word),
        .pop(rx_pop), .dout(bus.rx_data), .count(rx_count)
    );

    assign tx_empty     = (tx_count == '0);
    assign bus.tx_ready = !tx_count[AW];
    assign bus.rx_valid = (rx_count != '0);
    assign rx_full      = rx_count[AW];
    assign rx_pop       = bus.rx_valid && bus.rx_ready;
    // A word may start only if its result will have somewhere to land
    assign rx_space     = !rx_full || rx_pop;
    assign rx_space_nx  = (int'(rx_count) + 1 - int'(rx_pop)) < DEPTH;

`ifdef SPI_LOOPBACK_EN
    assign miso_s = loopback ? spi_mosi : spi_miso;
`else
    assign miso_s = spi_miso;
`endif

    // Tick index k = bit_cnt+1; odd k is a leading SCLK edge
    assign tick       = (state != IDLE) && (div_cnt == '0);
    assign last       = (bit_cnt == LAST);
    assign sample_now = tick && (state == SHIFT) && (cpha_l ? bit_cnt[0] : !bit_cnt[0]);
    assign load_now   = tick && (state == SHIFT) && (cpha_l ? !bit_cnt[0] : (bit_cnt[0] && !last));
    assign rx_shift   = lsb_l ? {miso_s, rxreg[WIDTH-1:1]} : {rxreg[WIDTH-2:0], miso_s};
    assign rx_word    = sample_now ? rx_shift : rxreg;

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and FIFO strobes
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        cont     = 1'b0;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        case (state)
            IDLE:  if (!tx_empty && rx_space) begin
                       start    = 1'b1;
                       tx_pop   = 1'b1;
                       state_nx = LEAD;
                   end
            LEAD:  if (tick) state_nx = SHIFT;
            SHIFT: if (tick && last) begin
                       rx_push = 1'b1;
                       if (!tx_empty && rx_space_nx) begin
                           cont   = 1'b1;
                           tx_pop = 1'b1;
                       end else begin
                           state_nx = TRAIL;
                       end
                   end
            TRAIL: if (tick) state_nx = GAP;
            GAP:   if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Divider, bit counter, shifters and pin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            div_l      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rxreg      <= '0;
            cpol_l     <= 1'b0;
            cpha_l     <= 1'b0;
            lsb_l      <= 1'b0;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
            cs_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (start)               div_cnt <= clk_div;
            else if (state != IDLE)  div_cnt <= (div_cnt == '0) ? div_l : div_cnt - 1'b1;

            if (state == IDLE)              spi_clk <= mode[1];
            else if (tick && state == SHIFT) spi_clk <= !spi_clk;

            if (start) begin
                div_l   <= clk_div;
                cpol_l  <= mode[1];
                cpha_l  <= mode[0];
                lsb_l   <= lsb_first;
                bit_cnt <= '0;
                cs_n    <= ~(NUM_CS'(1) << cs_sel);
                // CPHA=0 must present the first bit before the first edge
                if (!mode[0]) begin
                    spi_mosi <= out_bit(tx_head, lsb_first);
                    shreg    <= shift_out(tx_head, lsb_first);
                end else begin
                    shreg    <= tx_head;
                end
            end else if (cont) begin
                bit_cnt <= '0;
                if (!cpha_l) begin
                    spi_mosi <= out_bit(tx_head, lsb_l);
                    shreg    <= shift_out(tx_head, lsb_l);
                end else begin
                    shreg    <= tx_head;
                end
            end else if (load_now) begin
                spi_mosi <= out_bit(shreg, lsb_l);
                shreg    <= shift_out(shreg, lsb_l);
            end

            if (tick && state == SHIFT && !last) bit_cnt <= bit_cnt + 1'b1;
            if (tick && state == TRAIL) begin
                cs_n       <= '1;
                frame_done <= 1'b1;
            end

            if (sample_now) rxreg <= rx_shift;
        end
    end
endmodule
